// File: rtl/obj_line_scan_if.sv
// Object-RAM read port plus the hit stream toward the sprite line renderer.
interface obj_line_scan_if;
  logic [8:0]  obj_addr;
  logic [63:0] obj_q64;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_obj;
  logic [6:0]  out_row;

  modport master (output obj_addr, out_valid, out_obj, out_row,
                  input  obj_q64, out_ready);
  modport slave  (input  obj_addr, out_valid, out_obj, out_row,
                  output obj_q64, out_ready);
endinterface

// File: rtl/obj_line_scan.sv
// Per-scanline object walker: reads each entry, tests its vertical extent against the line,
// and queues hits (entry + row) in a show-ahead FIFO; reads stall when the FIFO could overfill.
module obj_line_scan #(
  parameter int MAX_HITS   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   line_start,
  input  logic [8:0]             line,
  input  logic [9:0]             obj_count,
  obj_line_scan_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(MAX_HITS + 1);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;
  state_t state, state_nxt;

  logic [8:0]    line_q, addr_q;
  logic [9:0]    count_q;
  logic          rd_vld;
  logic [HW-1:0] hit_cnt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [70:0]   fifo_mem [FIFO_DEPTH];
  logic          issue, last_issue, done_nxt;
  logic          hit, push, drop, pop;
  logic [8:0]    delta, height;

  // Compare the entry returned for last cycle's read; a restart discards it.
  assign delta  = line_q - bus.obj_q64[8:0];
  assign height = 9'd16 << bus.obj_q64[10:9];
  assign hit    = rd_vld && !line_start && (delta < height);
  assign push   = hit && (hit_cnt < HW'(MAX_HITS));
  assign drop   = hit && !(hit_cnt < HW'(MAX_HITS));
  assign pop    = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (line_start) begin
      state_nxt = (obj_count == 10'd0) ? IDLE : SCAN;
    end else begin
      case (state)
        SCAN:    if (last_issue) state_nxt = FLUSH;
        FLUSH:   state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // The in-flight read reserves a FIFO slot, so a hit never meets a full FIFO.
  always_comb begin
    issue      = (state == SCAN) && !line_start &&
                 (({1'b0, fifo_cnt} + {{CW{1'b0}}, rd_vld}) < (CW+1)'(FIFO_DEPTH));
    last_issue = issue && ({1'b0, addr_q} == count_q - 10'd1);
    done_nxt   = last_issue || (line_start && (obj_count == 10'd0));
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q   <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      rd_vld   <= 1'b0;
      hit_cnt  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= done_nxt;
      if (line_start) begin
        line_q   <= line;
        count_q  <= obj_count;
        addr_q   <= '0;
        rd_vld   <= 1'b0;
        hit_cnt  <= '0;
        overflow <= 1'b0;
      end else begin
        rd_vld <= issue;
        if (issue) addr_q   <= addr_q + 9'd1;
        if (push)  hit_cnt  <= hit_cnt + HW'(1);
        if (drop)  overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (line_start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {delta[6:0], bus.obj_q64};
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign bus.obj_addr              = addr_q;
  assign bus.out_valid             = (fifo_cnt != '0);
  assign {bus.out_row, bus.out_obj} = fifo_mem[rd_ptr];

endmodule

// File: doc/obj_line_scan.md
Name: obj_line_scan

Overview:
- Downstream consumer of the 512 x 64-bit object RAM. Reads its 64-bit port, one entry per address (`addr[10:2]`).
- On every scanline start, walks the object list, tests each entry's vertical extent against the target line, and streams hits into a small output FIFO.
- The sprite line renderer drains the FIFO over a valid/ready handshake.
- Caps hits per line and flags overflow.

Parameters:
- MAX_HITS, 32: maximum objects forwarded per line; further hits are dropped and counted as overflow.
- FIFO_DEPTH, 4: output FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- line_start  in  1  single-cycle pulse; starts a scan for `line`
- line  in  9  target scanline, sampled when `line_start` = 1
- obj_count  in  10  number of entries to scan (0..512), sampled with `line_start`
- obj_addr  out  9  entry address to the object RAM 64-bit port (registered)
- obj_q64  in  64  entry data; valid the cycle after `obj_addr` is presented
- out_valid  out  1  FIFO head valid
- out_ready  in  1  renderer accepts head when `out_valid` && `out_ready`
- out_obj  out  64  head entry, unmodified
- out_row  out  7  pixel row within the object: `(line - y) mod 512`, low 7 bits
- busy  out  1  scan in progress (SCAN state or read in flight)
- done  out  1  one-cycle pulse when the last entry of the scan has been compared
- overflow  out  1  sticky per line; set when a hit is dropped at MAX_HITS

Behaviour:
- Entry fields:
  - `y = q[8:0]`
  - `h = q[10:9]`; height = 16 << h rows (16/32/64/128)
  - Other fields are opaque pass-through.
- Hit test: `delta = (line - y) mod 512` (9-bit wrap); hit iff `delta < (16 << h)`. Wrap-around is therefore natural, e.g. y=500, h=1, line=4 gives delta=16, which is a hit.
- Reset values:
  - `obj_addr` = 0, `out_valid` = 0, `out_obj` = 0, `out_row` = 0
  - `busy` = 0, `done` = 0, `overflow` = 0
  - FIFO empty, state IDLE.
- States:
  - IDLE: waits for `line_start`. On `line_start`, latches `line`/`obj_count`, clears the hit counter, `overflow` and the FIFO, and goes to SCAN (if `obj_count` = 0, pulses `done` the next cycle and stays IDLE).
  - SCAN: each cycle, issues the read at `obj_addr` only when `fifo_count + inflight < FIFO_DEPTH`; otherwise holds the address (stall).
  - The last issue (`addr = obj_count - 1`) moves to FLUSH.
  - FLUSH: waits for the in-flight compare, pulses `done`, returns to IDLE.
- Pipeline:
  - Address issued in cycle n; `obj_q64` compared in cycle n+1.
  - A hit is written to the FIFO at the end of n+1; `out_valid` is visible from n+2.
  - Unstalled throughput is 1 entry/cycle. A full 512 scan ends with `done` at `line_start` + 513 cycles.
- Hit cap: once MAX_HITS hits are pushed, later hits set `overflow` and are discarded. Scanning continues to the end, so `done` timing is unchanged.
- FIFO:
  - Show-ahead (first-word-fall-through) behaviour; pop on `out_valid` && `out_ready`.
  - Simultaneous push and pop when full is legal; the issue gating guarantees no push into a full FIFO.
  - Order of output equals address order.
- `line_start` during SCAN/FLUSH: abort the current scan, discard the in-flight read, flush the FIFO (`out_valid` low next cycle), restart at address 0 with the new line.
- `line_start` coincident with `done`: the restart wins; `done` is still pulsed for the completed scan.
- `out_ready` may be held low indefinitely; the scan stalls and never loses or duplicates entries.
- Asynchronous reset mid-scan returns to IDLE immediately with all outputs at reset values.

Test Plan:
- Entries 0..3 with y = 100/120/200/95, h = 0; `line` = 105, `obj_count` = 4, `out_ready` = 1 -> exactly two outputs: entry 0 (row 5), then entry 3 (row 10); `done` pulses 5 cycles after `line_start`; `overflow` = 0.
- Wrap case: y=500, h=1, `line` = 4 -> hit with row 16; same entry with `line` = 20 -> no hit (delta = 32).
- 40 entries all hitting, MAX_HITS = 32 -> 32 outputs in address order, `overflow` = 1, `done` at `line_start` + 41 cycles.
- `out_ready` held 0 for 50 cycles while 10 entries hit -> `obj_addr` stalls with FIFO full (4 entries); after release, all 10 arrive in order with no gaps or duplicates.
- `line_start` reissued mid-scan at address 200 of 512 -> `out_valid` drops the next cycle, `obj_addr` returns to 0, and only new-line hits appear.
- `obj_count` = 0 -> `done` one cycle after `line_start`, `out_valid` never asserted; reset asserted mid-scan -> all outputs at reset values asynchronously.
